// File: rtl/pr_decoder38_seq_pkg.sv
// Shared defaults for the priority encode/decode pair.
package pr_decoder38_seq_pkg;

  localparam int unsigned PR_CODE_W = 3;
  localparam int unsigned PR_N_OUT  = 8;
  localparam int unsigned PR_CNT_W  = 8;

endpackage : pr_decoder38_seq_pkg

// File: rtl/pr_decoder38_seq_if.sv
// Sample/control/status bundle between the encoder side and the decoder block.
interface pr_decoder38_seq_if
  import pr_decoder38_seq_pkg::*;
#(
  parameter int unsigned CODE_W = PR_CODE_W,
  parameter int unsigned N_OUT  = PR_N_OUT,
  parameter int unsigned CNT_W  = PR_CNT_W
);

  logic [CODE_W-1:0] in_code;
  logic              in_idle;
  logic [N_OUT-1:0]  clr;
  logic              cnt_clr;
  logic [N_OUT-1:0]  irq_en;
  logic [N_OUT-1:0]  out;
  logic              out_valid;
  logic              evt_pulse;
  logic [N_OUT-1:0]  pending;
  logic [CNT_W-1:0]  evt_count;
  logic              irq;

  modport master (
    output in_code, in_idle, clr, cnt_clr, irq_en,
    input  out, out_valid, evt_pulse, pending, evt_count, irq
  );

  modport slave (
    input  in_code, in_idle, clr, cnt_clr, irq_en,
    output out, out_valid, evt_pulse, pending, evt_count, irq
  );

endinterface : pr_decoder38_seq_if

// File: rtl/pr_decoder38_seq_decode_comb.sv
// Combinational index -> one-hot decode, forced to zero while idle.
module pr_decode_comb
  import pr_decoder38_seq_pkg::*;
#(
  parameter int unsigned CODE_W = PR_CODE_W,
  parameter int unsigned N_OUT  = PR_N_OUT
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic              idle_i,
  output logic [N_OUT-1:0]  onehot_o
);

  // One bit per line; no bit when the source reports idle.
  always_comb begin
    onehot_o = '0;
    if (!idle_i) begin
      onehot_o[code_i] = 1'b1;
    end
  end

endmodule : pr_decode_comb

// File: rtl/pr_decoder38_seq.sv
// Receive-side decoder: registered one-hot, event detect, sticky pending,
// saturating event counter and maskable interrupt.
module pr_decoder38_seq
  import pr_decoder38_seq_pkg::*;
#(
  parameter int unsigned CODE_W = PR_CODE_W,
  parameter int unsigned N_OUT  = PR_N_OUT,
  parameter int unsigned CNT_W  = PR_CNT_W
) (
  input logic               clk,
  input logic               rst_n,
  pr_decoder38_seq_if.slave bus
);

  logic [N_OUT-1:0]  dec;
  logic              new_evt;

  logic [N_OUT-1:0]  out_q;
  logic              out_valid_q;
  logic              evt_pulse_q;
  logic [N_OUT-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  evt_count_q, evt_count_d;
  logic              irq_q;
  logic              prev_idle_q;
  logic [CODE_W-1:0] prev_code_q;

  pr_decode_comb #(
    .CODE_W (CODE_W),
    .N_OUT  (N_OUT)
  ) u_decode (
    .code_i   (bus.in_code),
    .idle_i   (bus.in_idle),
    .onehot_o (dec)
  );

  // A new event is an active sample after idle, or a change of active code.
  always_comb begin
    new_evt = !bus.in_idle && (prev_idle_q || (bus.in_code != prev_code_q));
  end

  // Sticky flags: W1C first, then set, so a same-edge set wins over clear.
  always_comb begin
    pending_d = pending_q & ~bus.clr;
    if (new_evt) begin
      pending_d = pending_d | dec;
    end
  end

  // Saturating counter; a clear coinciding with an event leaves a count of one.
  always_comb begin
    evt_count_d = evt_count_q;
    if (bus.cnt_clr) begin
      evt_count_d = new_evt ? CNT_W'(1) : '0;
    end else if (new_evt && (evt_count_q != '1)) begin
      evt_count_d = evt_count_q + CNT_W'(1);
    end
  end

  // All status state, including sample history, advances every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      evt_pulse_q <= 1'b0;
      pending_q   <= '0;
      evt_count_q <= '0;
      irq_q       <= 1'b0;
      prev_idle_q <= 1'b1;
      prev_code_q <= '0;
    end else begin
      out_q       <= dec;
      out_valid_q <= !bus.in_idle;
      evt_pulse_q <= new_evt;
      pending_q   <= pending_d;
      evt_count_q <= evt_count_d;
      irq_q       <= |(pending_q & bus.irq_en);
      prev_idle_q <= bus.in_idle;
      prev_code_q <= bus.in_code;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.evt_pulse = evt_pulse_q;
  assign bus.pending   = pending_q;
  assign bus.evt_count = evt_count_q;
  assign bus.irq       = irq_q;

endmodule : pr_decoder38_seq

// File: tb/tb_pr_decoder38_seq.sv
// Directed self-checking bench for pr_decoder38_seq.
module tb_pr_decoder38_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pr_decoder38_seq_if #(.CODE_W(3), .N_OUT(8), .CNT_W(8)) bus ();

  pr_decoder38_seq #(.CODE_W(3), .N_OUT(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_val,
                         input logic e_pulse, input logic [7:0] e_pend,
                         input logic [7:0] e_cnt, input logic e_irq);
    chk({tag, ".out"},       32'(bus.out),       32'(e_out));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e_val));
    chk({tag, ".evt_pulse"}, 32'(bus.evt_pulse), 32'(e_pulse));
    chk({tag, ".pending"},   32'(bus.pending),   32'(e_pend));
    chk({tag, ".evt_count"}, 32'(bus.evt_count), 32'(e_cnt));
    chk({tag, ".irq"},       32'(bus.irq),       32'(e_irq));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.in_code = 3'd5;
    bus.in_idle = 1'b0;
    bus.clr     = 8'h00;
    bus.cnt_clr = 1'b0;
    bus.irq_en  = 8'h00;

    // 1: reset holds everything at zero despite an active input
    tick();
    tick();
    chk_all("rst", 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("first", 8'h20, 1'b1, 1'b1, 8'h20, 8'd1, 1'b0);

    // 2: steady code is one event; code change is another
    bus.in_code = 3'd3;
    bus.clr     = 8'h20;
    tick();
    chk_all("hold3_0", 8'h08, 1'b1, 1'b1, 8'h08, 8'd2, 1'b0);
    bus.clr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("hold3", 8'h08, 1'b1, 1'b0, 8'h08, 8'd2, 1'b0);
    end
    bus.in_code = 3'd6;
    tick();
    chk_all("chg6", 8'h40, 1'b1, 1'b1, 8'h48, 8'd3, 1'b0);

    // 3: idle gap between identical codes gives two events
    bus.in_code = 3'd2;
    bus.clr     = 8'hFF;
    tick();
    chk_all("gap_a", 8'h04, 1'b1, 1'b1, 8'h04, 8'd4, 1'b0);
    bus.clr     = 8'h00;
    bus.in_idle = 1'b1;
    tick();
    chk_all("gap_idle", 8'h00, 1'b0, 1'b0, 8'h04, 8'd4, 1'b0);
    bus.in_idle = 1'b0;
    tick();
    chk_all("gap_b", 8'h04, 1'b1, 1'b1, 8'h04, 8'd5, 1'b0);

    // 4: W1C racing a set on the same line: set wins
    bus.in_code = 3'd1;
    tick();
    chk_all("w1c_set", 8'h02, 1'b1, 1'b1, 8'h06, 8'd6, 1'b0);
    bus.in_idle = 1'b1;
    tick();
    chk("w1c_idle.pending", 32'(bus.pending), 32'h06);
    bus.in_idle = 1'b0;
    bus.clr     = 8'h02;
    tick();
    chk_all("w1c_race", 8'h02, 1'b1, 1'b1, 8'h06, 8'd7, 1'b0);
    tick();
    chk_all("w1c_alone", 8'h02, 1'b1, 1'b0, 8'h04, 8'd7, 1'b0);

    // 6: interrupt masking and one-cycle lag behind pending/irq_en
    bus.clr     = 8'hFF;
    bus.in_code = 3'd0;
    tick();
    chk("irq_p01.pending", 32'(bus.pending), 32'h01);
    bus.clr     = 8'h00;
    bus.in_code = 3'd7;
    tick();
    chk_all("irq_p81", 8'h80, 1'b1, 1'b1, 8'h81, 8'd9, 1'b0);
    bus.irq_en = 8'h01;
    tick();
    chk("irq_en.irq", 32'(bus.irq), 32'd1);
    bus.clr = 8'h01;
    tick();
    chk("irq_clr0.pending", 32'(bus.pending), 32'h80);
    chk("irq_clr0.irq", 32'(bus.irq), 32'd1);
    bus.clr = 8'h00;
    tick();
    chk("irq_clr1.irq", 32'(bus.irq), 32'd0);

    // 5: counter saturation and clear interactions
    for (int i = 0; i < 260; i++) begin
      bus.in_code = (i % 2 == 1) ? 3'd1 : 3'd0;
      tick();
    end
    chk("sat.evt_count", 32'(bus.evt_count), 32'd255);
    chk("sat.evt_pulse", 32'(bus.evt_pulse), 32'd1);
    bus.in_code = 3'd0;
    tick();
    chk("sat_hold.evt_count", 32'(bus.evt_count), 32'd255);
    bus.in_code = 3'd1;
    bus.cnt_clr = 1'b1;
    tick();
    chk("clr_evt.evt_count", 32'(bus.evt_count), 32'd1);
    tick();
    chk("clr_only.evt_count", 32'(bus.evt_count), 32'd0);
    bus.cnt_clr = 1'b0;

    // 6 (cont): asynchronous reset mid-operation, then restart
    bus.irq_en = 8'hFF;
    tick();
    chk("pre_rst.pending", 32'(bus.pending), 32'h83);
    chk("pre_rst.irq", 32'(bus.irq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0);
    bus.in_code = 3'd4;
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("restart", 8'h10, 1'b1, 1'b1, 8'h10, 8'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pr_decoder38_seq
